// File: rtl/pyramid_cntr_gen.sv
// Triangular/pyramid row counter with start control, enable freeze, and row/done pulses.
// Define PYRAMID_CNTR_REPEAT_EN to restart the sequence automatically instead of stopping in DONE.
module pyramid_cntr_gen #(
  parameter int WIDTH = 4,
  parameter int TOP   = 2**WIDTH-1
) (
  input  logic             up,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             mode,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] limit,
  output logic             row_pulse,
  output logic             done_pulse,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] TOP_V = WIDTH'(TOP);

  state_t           state;
  state_t           state_nxt;
  logic             mode_q;
  logic             mode_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic [WIDTH-1:0] limit_nxt;
  logic             row_nxt;
  logic             done_nxt;
  logic             busy_nxt;
  logic             row_end;
  logic             last_row;

  assign row_end  = (out == limit);
  assign last_row = mode_q ? (limit == TOP_V) : (limit == '0);

  // All state updates on the falling edge of up.
  always_ff @(negedge up or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      out        <= '0;
      limit      <= '0;
      row_pulse  <= 1'b0;
      done_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      mode_q     <= mode_nxt;
      out        <= out_nxt;
      limit      <= limit_nxt;
      row_pulse  <= row_nxt;
      done_pulse <= done_nxt;
      busy       <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (enable) begin
      unique case (state)
        IDLE, DONE: if (start) state_nxt = RUN;
        RUN: begin
          if (row_end && last_row) begin
`ifdef PYRAMID_CNTR_REPEAT_EN
            state_nxt = RUN;
`else
            state_nxt = DONE;
`endif
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath and pulse outputs; the check for the last row comes before any limit step so limit never wraps.
  always_comb begin
    mode_nxt  = mode_q;
    out_nxt   = out;
    limit_nxt = limit;
    row_nxt   = 1'b0;
    done_nxt  = 1'b0;
    if (enable) begin
      unique case (state)
        IDLE, DONE: begin
          out_nxt = '0;
          if (start) begin
            mode_nxt  = mode;
            limit_nxt = mode ? '0 : TOP_V;
          end
        end
        RUN: begin
          if (!row_end) begin
            out_nxt = out + 1'b1;
          end else begin
            out_nxt = '0;
            row_nxt = 1'b1;
            if (last_row) begin
              done_nxt = 1'b1;
`ifdef PYRAMID_CNTR_REPEAT_EN
              limit_nxt = mode_q ? '0 : TOP_V;
`endif
            end else begin
              limit_nxt = mode_q ? (limit + 1'b1) : (limit - 1'b1);
            end
          end
        end
        default: out_nxt = '0;
      endcase
    end
    busy_nxt = (state_nxt == RUN);
  end

endmodule

// File: tb/tb_pyramid_cntr_gen.sv
// Directed bench for pyramid_cntr_gen: a TOP=3 unit, a default unit, and a TOP=2 unit sharing one clock.
// Expected values are hand-derived sequences; the PYRAMID_CNTR_REPEAT_EN build swaps in the repeating expectations.
module tb_pyramid_cntr_gen;

`ifdef PYRAMID_CNTR_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       up = 1'b1;
  logic       reset;
  logic       enable;
  logic       mode;
  logic       start_s, start_d, start_r;
  logic [3:0] out_s, limit_s, out_d, limit_d, out_r, limit_r;
  logic       row_s, done_s, busy_s;
  logic       row_d, done_d, busy_d;
  logic       row_r, done_r, busy_r;

  int checkCount = 0;
  int passCount  = 0;

  pyramid_cntr_gen #(.WIDTH(4), .TOP(3)) dut_s (
    .up(up), .reset(reset), .enable(enable), .start(start_s), .mode(mode),
    .out(out_s), .limit(limit_s), .row_pulse(row_s), .done_pulse(done_s), .busy(busy_s)
  );

  pyramid_cntr_gen dut_d (
    .up(up), .reset(reset), .enable(enable), .start(start_d), .mode(mode),
    .out(out_d), .limit(limit_d), .row_pulse(row_d), .done_pulse(done_d), .busy(busy_d)
  );

  pyramid_cntr_gen #(.WIDTH(4), .TOP(2)) dut_r (
    .up(up), .reset(reset), .enable(enable), .start(start_r), .mode(mode),
    .out(out_r), .limit(limit_r), .row_pulse(row_r), .done_pulse(done_r), .busy(busy_r)
  );

  always #5 up = ~up;

  // Drive inputs, let one falling (active) edge pass, then return on the rising edge for sampling.
  task automatic applyStimulus(input logic en, input logic ss, input logic sd,
                               input logic sr, input logic md);
    enable  = en;
    start_s = ss;
    start_d = sd;
    start_r = sr;
    mode    = md;
    @(negedge up);
    @(posedge up);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    int expOutA[9] = '{1, 2, 3, 0, 1, 2, 0, 1, 0};
    int expLimA[9] = '{3, 3, 3, 2, 2, 2, 1, 1, 0};
    int expRowA[9] = '{0, 0, 0, 1, 0, 0, 1, 0, 1};
    int expOutB[9] = '{0, 1, 0, 1, 2, 0, 1, 2, 3};
    int expLimB[9] = '{1, 1, 2, 2, 2, 3, 3, 3, 3};
    int expRowB[9] = '{1, 0, 1, 0, 0, 1, 0, 0, 0};
    int patR[6]    = '{0, 1, 2, 0, 1, 0};
    int k;
    int rows;
    bit seen;

    reset = 1'b0; enable = 1'b0; mode = 1'b0;
    start_s = 1'b0; start_d = 1'b0; start_r = 1'b0;
    #12;
    checkOutput("rst_out_s", out_s, 0);
    checkOutput("rst_limit_s", limit_s, 0);
    checkOutput("rst_busy_s", busy_s, 0);
    checkOutput("rst_pulses_s", {row_s, done_s}, 0);
    checkOutput("rst_out_d", out_d, 0);
    checkOutput("rst_limit_d", limit_d, 0);
    reset = 1'b1;
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("idle_busy_s", busy_s, 0);
    checkOutput("idle_out_s", out_s, 0);

    // Abort a default-size run at out=5, limit=12 with an asynchronous reset.
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("d_start_out", out_d, 0);
    checkOutput("d_start_limit", limit_d, 15);
    checkOutput("d_start_busy", busy_d, 1);
    for (int i = 0; i < 50; i++) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("d_mid_out", out_d, 5);
    checkOutput("d_mid_limit", limit_d, 12);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_rst_out", out_d, 0);
    checkOutput("async_rst_limit", limit_d, 0);
    checkOutput("async_rst_busy", busy_d, 0);
    #1 reset = 1'b1;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("post_rst_busy", busy_d, 0);
    checkOutput("post_rst_out", out_d, 0);
    checkOutput("post_rst_limit", limit_d, 0);

    // TOP=3 shrinking rows; start re-pulsed and mode toggled mid-run.
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("a_e0_out", out_s, 0);
    checkOutput("a_e0_limit", limit_s, 3);
    checkOutput("a_e0_busy", busy_s, 1);
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1, (i >= 2 && i <= 4), 0, 0, i[0]);
      checkOutput($sformatf("a_e%0d_out", i), out_s, expOutA[i-1]);
      checkOutput($sformatf("a_e%0d_limit", i), limit_s, expLimA[i-1]);
      checkOutput($sformatf("a_e%0d_row", i), row_s, expRowA[i-1]);
      checkOutput($sformatf("a_e%0d_done", i), done_s, 0);
      checkOutput($sformatf("a_e%0d_busy", i), busy_s, 1);
    end
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("a_end_row", row_s, 1);
    checkOutput("a_end_done", done_s, 1);
    checkOutput("a_end_out", out_s, 0);
    checkOutput("a_end_limit", limit_s, REP ? 3 : 0);
    checkOutput("a_end_busy", busy_s, REP ? 1 : 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("a_after_pulses", {row_s, done_s}, 0);
    checkOutput("a_after_out", out_s, REP ? 1 : 0);
    checkOutput("a_after_limit", limit_s, REP ? 3 : 0);
    checkOutput("a_after_busy", busy_s, REP ? 1 : 0);
`ifdef PYRAMID_CNTR_REPEAT_EN
    #2 reset = 1'b0;
    #2 reset = 1'b1;
`endif

    // TOP=3 growing rows; mode input dropped back to 0 right after start.
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("b_e0_out", out_s, 0);
    checkOutput("b_e0_limit", limit_s, 0);
    checkOutput("b_e0_busy", busy_s, 1);
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput($sformatf("b_e%0d_out", i), out_s, expOutB[i-1]);
      checkOutput($sformatf("b_e%0d_limit", i), limit_s, expLimB[i-1]);
      checkOutput($sformatf("b_e%0d_row", i), row_s, expRowB[i-1]);
      checkOutput($sformatf("b_e%0d_done", i), done_s, 0);
    end
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("b_end_row", row_s, 1);
    checkOutput("b_end_done", done_s, 1);
    checkOutput("b_end_limit", limit_s, REP ? 0 : 3);
    checkOutput("b_end_busy", busy_s, REP ? 1 : 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("b_hold_limit", limit_s, REP ? 0 : 3);
    checkOutput("b_hold_done", done_s, 0);

    // Default size with a 3-cycle freeze at out=7.
    applyStimulus(1, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("c_pre_out", out_d, 7);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput($sformatf("c_frz%0d_out", i), out_d, 7);
      checkOutput($sformatf("c_frz%0d_limit", i), limit_d, 15);
      checkOutput($sformatf("c_frz%0d_pulses", i), {row_d, done_d}, 0);
      checkOutput($sformatf("c_frz%0d_busy", i), busy_d, 1);
    end
    k = 0;
    rows = 0;
    seen = 1'b0;
    while (!seen && k < 300) begin
      applyStimulus(1, 0, 0, 0, 0);
      k++;
      if (row_d) rows++;
      if (done_d) seen = 1'b1;
    end
    checkOutput("c_total_edges", 10 + k, 139);
    checkOutput("c_row_pulses", rows, 16);
    checkOutput("c_end_busy", busy_d, REP ? 1 : 0);

    // TOP=2 run: stops in DONE by default, repeats every 6 cycles in the repeat build.
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("r_e0_out", out_r, 0);
    checkOutput("r_e0_limit", limit_r, 2);
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      if (REP) begin
        checkOutput($sformatf("r_e%0d_out", i), out_r, patR[i % 6]);
        checkOutput($sformatf("r_e%0d_done", i), done_r, (i % 6) == 0);
        checkOutput($sformatf("r_e%0d_busy", i), busy_r, 1);
      end else begin
        checkOutput($sformatf("r_e%0d_out", i), out_r, (i < 6) ? patR[i] : 0);
        checkOutput($sformatf("r_e%0d_done", i), done_r, i == 6);
        checkOutput($sformatf("r_e%0d_busy", i), busy_r, i < 6);
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
